// File: rtl/mac_arbiter.sv
// Two-requester round-robin arbiter in front of a single MAC, with a registered response port.
// Define MAC_ARB_TIMEOUT_EN to compile in the BUSY timeout/abort path.
module mac_arbiter #(
    parameter int unsigned ACC_W   = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    output logic [1:0]       gnt,
    output logic             mac_go,
    input  logic             mac_done,
    input  logic [ACC_W-1:0] mac_out,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [ACC_W-1:0] rsp_data,
    output logic             rsp_err,
    input  logic             rsp_ready
);

    typedef enum logic [1:0] {StIdle, StIssue, StBusy, StResp} state_e;

    state_e state_q;
    logic   last_q;   // index of the requester served most recently
    logic   win_id;

`ifdef MAC_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    logic [CntW-1:0] cnt_q;
`else
    assign rsp_err = 1'b0;
`endif

    // On a tie the requester not served last wins.
    always_comb begin
        win_id = 1'b0;
        unique case (req)
            2'b01:   win_id = 1'b0;
            2'b10:   win_id = 1'b1;
            2'b11:   win_id = ~last_q;
            default: win_id = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            last_q    <= 1'b1;
            gnt       <= 2'b00;
            mac_go    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
`ifdef MAC_ARB_TIMEOUT_EN
            rsp_err   <= 1'b0;
            cnt_q     <= '0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    mac_go <= 1'b0;
                    if (req != 2'b00) begin
                        gnt     <= win_id ? 2'b10 : 2'b01;
                        mac_go  <= 1'b1;
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    mac_go  <= 1'b0;
                    state_q <= StBusy;
`ifdef MAC_ARB_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                end
                StBusy: begin
                    if (mac_done) begin
                        rsp_data  <= mac_out;
                        rsp_id    <= gnt[1];
                        rsp_valid <= 1'b1;
                        last_q    <= gnt[1];
                        state_q   <= StResp;
`ifdef MAC_ARB_TIMEOUT_EN
                        rsp_err   <= 1'b0;
                    end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                        // This edge closes the TIMEOUT-th BUSY cycle without a result.
                        rsp_data  <= '0;
                        rsp_id    <= gnt[1];
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        last_q    <= gnt[1];
                        state_q   <= StResp;
                    end else begin
                        cnt_q     <= cnt_q + 1'b1;
`endif
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        gnt       <= 2'b00;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
